cpu_control: RTL

CPU_CONTROL -- requirements
Module: cpu_control

---
 rtl/cpu_control.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cpu_control.sv
// Control FSM for a small bus-based CPU: decodes a latched instruction into per-cycle datapath
// enables. Optional retired-instruction counter enabled by CPU_CONTROL_INSTR_COUNT_EN.
module cpu_control (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] instr,
    output logic       busy,
    output logic       Done,
    output logic [1:0] op_code,
    output logic       data_in,
    output logic       R0_out,
    output logic       R1_out,
    output logic       R2_out,
    output logic       R3_out,
    output logic       R0_buff,
    output logic       R1_buff,
    output logic       R2_buff,
    output logic       R3_buff,
    output logic       Store_out,
    output logic       ALU_in_Ext,
    output logic       ALU_out_Ext,
    output logic       alu_open,
    output logic [7:0] instr_count
);

    typedef enum logic [1:0] {StIdle, StT1, StT2, StT3} state_e;

    localparam logic [2:0] OpLoad  = 3'b000;
    localparam logic [2:0] OpMove  = 3'b001;
    localparam logic [2:0] OpStore = 3'b110;

    state_e     state_q, state_d;
    logic [7:0] ir_q;
    logic [2:0] opcode;
    logic [1:0] rx, ry;
    logic       is_alu;
    logic [3:0] rx_oh, ry_oh;
    logic [3:0] r_out, r_buff;
    logic       unused_ir;

    assign opcode    = ir_q[7:5];
    assign rx        = ir_q[4:3];
    assign ry        = ir_q[2:1];
    assign unused_ir = ir_q[0];
    assign is_alu    = (opcode >= 3'b010) && (opcode <= 3'b101);
    assign rx_oh     = 4'b0001 << rx;
    assign ry_oh     = 4'b0001 << ry;

    // IR only loads on the accepting IDLE edge, so run/instr are ignored while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && run) begin
                ir_q <= instr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (run) state_d = StT1;
            StT1:    state_d = is_alu ? StT2 : StIdle;
            StT2:    state_d = StT3;
            StT3:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy        = (state_q != StIdle);
        Done        = 1'b0;
        op_code     = 2'b00;
        data_in     = 1'b0;
        r_out       = 4'b0000;
        r_buff      = 4'b0000;
        Store_out   = 1'b0;
        ALU_in_Ext  = 1'b0;
        ALU_out_Ext = 1'b0;
        alu_open    = 1'b0;
        // ALU opcodes 010..101 map to selects 00..11.
        if (busy && is_alu) begin
            op_code = opcode[1:0] + 2'd2;
        end
        unique case (state_q)
            StT1: begin
                if (is_alu) begin
                    r_buff     = rx_oh;
                    ALU_in_Ext = 1'b1;
                end else begin
                    Done = 1'b1;
                    case (opcode)
                        OpLoad: begin
                            data_in = 1'b1;
                            r_out   = rx_oh;
                        end
                        OpMove: begin
                            r_buff = ry_oh;
                            r_out  = rx_oh;
                        end
                        OpStore: begin
                            r_buff    = rx_oh;
                            Store_out = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            StT2: begin
                r_buff      = ry_oh;
                ALU_out_Ext = 1'b1;
            end
            StT3: begin
                alu_open = 1'b1;
                r_out    = rx_oh;
                Done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign {R3_out, R2_out, R1_out, R0_out}     = r_out;
    assign {R3_buff, R2_buff, R1_buff, R0_buff} = r_buff;

`ifdef CPU_CONTROL_INSTR_COUNT_EN
    logic [7:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 8'h00;
        end else if (Done) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign instr_count = count_q;
`else
    assign instr_count = 8'h00;
`endif

endmodule
